// File: rtl/trap_controller_pkg.sv
// Shared constants for the trap controller: cause codes, FSM state encoding and
// the vector table stride.
package trap_controller_pkg;

  localparam int NUM_CAUSES = 6;

  localparam logic [2:0] CAUSE_NONE        = 3'd0;
  localparam logic [2:0] CAUSE_MEM_CORRUPT = 3'd1;
  localparam logic [2:0] CAUSE_MEM_VIOL    = 3'd2;
  localparam logic [2:0] CAUSE_DIV_ZERO    = 3'd3;
  localparam logic [2:0] CAUSE_OVERFLOW    = 3'd4;
  localparam logic [2:0] CAUSE_UNDERFLOW   = 3'd5;
  localparam logic [2:0] CAUSE_TRAP        = 3'd6;

  // Request bit i carries cause i+1; bit 0 (memory corruption) is the only fatal one.
  localparam logic [NUM_CAUSES-1:0] NONFATAL_MASK = 6'b111110;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FLUSH   = 3'd1;
  localparam state_t ST_SAVE    = 3'd2;
  localparam state_t ST_VECTOR  = 3'd3;
  localparam state_t ST_HANDLER = 3'd4;
  localparam state_t ST_RETURN  = 3'd5;
  localparam state_t ST_HALT    = 3'd6;

  // Each vector table entry is 16 bytes wide.
  localparam int VEC_SHIFT = 4;

endpackage

// File: rtl/trap_controller_priority_encoder.sv
// Fixed-priority encoder over the six trap requests: lowest set bit wins and is
// reported both as a cause code and as a one-hot grant.
module trap_priority_encoder
  import trap_controller_pkg::*;
(
  input  logic [NUM_CAUSES-1:0] req,
  output logic [2:0]            cause,
  output logic [NUM_CAUSES-1:0] grant
);

  always_comb begin
    cause = CAUSE_NONE;
    grant = '0;
    if (req[0]) begin
      cause = CAUSE_MEM_CORRUPT;
      grant = 6'b000001;
    end else if (req[1]) begin
      cause = CAUSE_MEM_VIOL;
      grant = 6'b000010;
    end else if (req[2]) begin
      cause = CAUSE_DIV_ZERO;
      grant = 6'b000100;
    end else if (req[3]) begin
      cause = CAUSE_OVERFLOW;
      grant = 6'b001000;
    end else if (req[4]) begin
      cause = CAUSE_UNDERFLOW;
      grant = 6'b010000;
    end else if (req[5]) begin
      cause = CAUSE_TRAP;
      grant = 6'b100000;
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap entry/exit sequencer: picks the highest-priority status flag, drains the
// pipeline, saves the faulting PC, vectors to the handler and restores on return.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE = 32'h0000_0100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memory_corruption,
  input  logic                  memory_violation,
  input  logic                  division_by_zero,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  trap_instruction,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pipeline_empty,
  input  logic                  return_from_trap,
  output logic                  stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flags_clear,
  output logic                  trap_mode,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [2:0]            cause
);

  logic [NUM_CAUSES-1:0] flags;
  logic [NUM_CAUSES-1:0] req;
  logic [NUM_CAUSES-1:0] pending_q;
  logic [2:0]            req_cause;
  logic [NUM_CAUSES-1:0] req_grant;
  logic [2:0]            win_cause_q;
  logic [NUM_CAUSES-1:0] win_grant_q;
  logic [ADDR_WIDTH-1:0] pc_tmp_q;
  logic [ADDR_WIDTH-1:0] vector_addr;
  state_t                state_q;
  state_t                state_d;

  assign flags = {trap_instruction, underflow, overflow,
                  division_by_zero, memory_violation, memory_corruption};
  assign req   = flags | pending_q;

  assign vector_addr = VECTOR_BASE + (ADDR_WIDTH'(cause) << VEC_SHIFT);

  trap_priority_encoder u_prio (
    .req   (req),
    .cause (req_cause),
    .grant (req_grant)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req) state_d = ST_FLUSH;
      ST_FLUSH:   if (pipeline_empty) state_d = ST_SAVE;
      ST_SAVE:    state_d = ST_VECTOR;
      ST_VECTOR:  state_d = ST_HANDLER;
      ST_HANDLER: begin
        // A fatal error inside the handler wins over a simultaneous return.
        if (memory_corruption)     state_d = ST_HALT;
        else if (return_from_trap) state_d = ST_RETURN;
      end
      ST_RETURN:  state_d = ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Cause/PC capture and pending bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_cause_q <= CAUSE_NONE;
      win_grant_q <= '0;
      pc_tmp_q    <= '0;
      pending_q   <= '0;
      epc         <= '0;
      cause       <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            win_cause_q <= req_cause;
            win_grant_q <= req_grant;
            pc_tmp_q    <= pc_in;
          end
        end
        ST_SAVE: begin
          epc       <= pc_tmp_q;
          cause     <= win_cause_q;
          pending_q <= pending_q & ~win_grant_q;
        end
        ST_HANDLER: begin
          pending_q <= pending_q | (flags & NONFATAL_MASK);
        end
        default: ;
      endcase
    end
  end

  // Registered Moore outputs, one cycle behind the state they decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      flags_clear    <= 1'b0;
      trap_mode      <= 1'b0;
      halted         <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      stall          <= (state_q == ST_FLUSH) || (state_q == ST_SAVE) ||
                        (state_q == ST_VECTOR) || (state_q == ST_HALT);
      flush          <= (state_q == ST_FLUSH);
      redirect_valid <= (state_q == ST_VECTOR) || (state_q == ST_RETURN);
      flags_clear    <= (state_q == ST_VECTOR);
      trap_mode      <= (state_q == ST_HANDLER) || (state_q == ST_RETURN) ||
                        (state_q == ST_HALT);
      halted         <= (state_q == ST_HALT);
      if (state_q == ST_VECTOR) begin
        redirect_pc <= vector_addr;
      end else if (state_q == ST_RETURN) begin
        redirect_pc <= epc;
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized
// trap entry/return checked against a cause-priority and latency model.
module tb_trap_controller;

  localparam int          AW = 32;
  localparam logic [31:0] VB = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic        memory_corruption, memory_violation, division_by_zero;
  logic        overflow, underflow, trap_instruction;
  logic [31:0] pc_in;
  logic        pipeline_empty, return_from_trap;
  logic        stall, flush, redirect_valid, flags_clear, trap_mode, halted;
  logic [31:0] redirect_pc, epc;
  logic [2:0]  cause;

  int errors = 0;
  int checks = 0;

  trap_controller #(.ADDR_WIDTH(AW), .VECTOR_BASE(VB)) dut (
    .clock             (clock),
    .reset             (reset),
    .memory_corruption (memory_corruption),
    .memory_violation  (memory_violation),
    .division_by_zero  (division_by_zero),
    .overflow          (overflow),
    .underflow         (underflow),
    .trap_instruction  (trap_instruction),
    .pc_in             (pc_in),
    .pipeline_empty    (pipeline_empty),
    .return_from_trap  (return_from_trap),
    .stall             (stall),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .flags_clear       (flags_clear),
    .trap_mode         (trap_mode),
    .halted            (halted),
    .epc               (epc),
    .cause             (cause)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Flag vector order: bit0 corruption ... bit5 trap instruction.
  task automatic set_flags(input logic [5:0] f);
    {trap_instruction, underflow, overflow, division_by_zero,
     memory_violation, memory_corruption} = f;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: causes in decreasing priority are 1..6, flag for cause c is bit c-1.
  function automatic logic [2:0] model_cause(input logic [5:0] f);
    for (int c = 1; c <= 6; c++) if (f[c-1]) return 3'(c);
    return 3'd0;
  endfunction

  function automatic logic [31:0] model_vector(input logic [2:0] c);
    return VB + 32'(c) * 32'd16;
  endfunction

  // Observes one entry sequence after the triggering edge; d = cycles pipeline_empty stays low.
  task automatic watch_entry(input int d, output int nflush, output int rdy_at,
                             output logic [31:0] rpc, output int bad);
    nflush = 0; rdy_at = -1; rpc = '0; bad = 0;
    pipeline_empty = (d == 0);
    for (int k = 1; k <= 40; k++) begin
      if (rdy_at >= 0) break;
      step();
      if (flush) nflush++;
      if (flush && !stall) bad++;
      if (redirect_valid) begin
        rdy_at = k;
        rpc    = redirect_pc;
        if (!flags_clear || !stall) bad++;
      end
      pipeline_empty = (k >= d);
    end
  endtask

  task automatic do_entry(input logic [5:0] f, input logic [31:0] pc, input int d,
                          output int nflush, output int rdy_at,
                          output logic [31:0] rpc, output int bad);
    set_flags(f);
    pc_in = pc;
    pipeline_empty = (d == 0);
    step();
    set_flags(6'b0);
    pc_in = $urandom;
    watch_entry(d, nflush, rdy_at, rpc, bad);
  endtask

  task automatic do_return(output logic rv1, output logic [31:0] rpc1, output logic tm1,
                           output logic tm2, output logic fl2);
    return_from_trap = 1'b1;
    step();
    return_from_trap = 1'b0;
    step();
    rv1 = redirect_valid; rpc1 = redirect_pc; tm1 = trap_mode;
    step();
    tm2 = trap_mode; fl2 = flush;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_flags(6'b0);
    pc_in = '0; pipeline_empty = 1'b1; return_from_trap = 1'b0;
    step(); step();
    checks++;
    if ({stall, flush, redirect_valid, flags_clear, trap_mode, halted} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {stall, flush, redirect_valid, flags_clear, trap_mode, halted});
    end
    checks++;
    if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h expected 0", epc); end
    checks++;
    if (cause !== 3'd0) begin errors++; $display("FAIL reset_cause: got %0d expected 0", cause); end
    checks++;
    if (redirect_pc !== 32'h0) begin
      errors++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_return_ignored();
    logic seen;
    seen = 1'b0;
    return_from_trap = 1'b1;
    step();
    return_from_trap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (redirect_valid || trap_mode) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL return_idle: got redirect/trap_mode 1 expected 0"); end
  endtask

  task automatic test_basic();
    int nf, ra, bad;
    logic [31:0] rpc, rpc1;
    logic rv1, tm1, tm2, fl2;
    do_entry(6'b000100, 32'h40, 0, nf, ra, rpc, bad);
    checks++;
    if (nf !== 1) begin errors++; $display("FAIL basic_flush_len: got %0d expected 1", nf); end
    checks++;
    if (ra !== 3) begin errors++; $display("FAIL basic_redirect_cycle: got %0d expected 3", ra); end
    checks++;
    if (rpc !== 32'h130) begin errors++; $display("FAIL basic_vector: got %h expected 00000130", rpc); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL basic_stall_clear: got %0d bad cycles expected 0", bad); end
    step();
    checks++;
    if ({trap_mode, stall, redirect_valid} !== 3'b100) begin
      errors++; $display("FAIL basic_handler: got %b expected 100", {trap_mode, stall, redirect_valid});
    end
    checks++;
    if (epc !== 32'h40) begin errors++; $display("FAIL basic_epc: got %h expected 00000040", epc); end
    checks++;
    if (cause !== 3'd3) begin errors++; $display("FAIL basic_cause: got %0d expected 3", cause); end
    do_return(rv1, rpc1, tm1, tm2, fl2);
    checks++;
    if ({rv1, tm1, tm2} !== 3'b110) begin
      errors++; $display("FAIL basic_return: got %b expected 110", {rv1, tm1, tm2});
    end
    checks++;
    if (rpc1 !== 32'h40) begin errors++; $display("FAIL basic_return_pc: got %h expected 00000040", rpc1); end
  endtask

  task automatic test_priority();
    int nf, ra, bad;
    logic [31:0] rpc, rpc1;
    logic rv1, tm1, tm2, fl2, refl;
    do_entry(6'b101000, 32'h200, 0, nf, ra, rpc, bad);
    checks++;
    if (rpc !== 32'h140) begin errors++; $display("FAIL prio_vector: got %h expected 00000140", rpc); end
    step();
    checks++;
    if (cause !== 3'd4) begin errors++; $display("FAIL prio_cause: got %0d expected 4", cause); end
    do_return(rv1, rpc1, tm1, tm2, fl2);
    refl = fl2;
    for (int i = 0; i < 4; i++) begin step(); if (flush || stall) refl = 1'b1; end
    checks++;
    if (refl !== 1'b0) begin errors++; $display("FAIL prio_no_retrap: got flush 1 expected 0"); end
  endtask

  task automatic test_flush_wait();
    int nf, ra, bad;
    logic [31:0] rpc, rpc1;
    logic rv1, tm1, tm2, fl2;
    do_entry(6'b000010, 32'h300, 4, nf, ra, rpc, bad);
    checks++;
    if (nf !== 5) begin errors++; $display("FAIL wait_flush_len: got %0d expected 5", nf); end
    checks++;
    if (ra !== 7) begin errors++; $display("FAIL wait_redirect_cycle: got %0d expected 7", ra); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wait_stall: got %0d bad cycles expected 0", bad); end
    step();
    do_return(rv1, rpc1, tm1, tm2, fl2);
    checks++;
    if (rpc1 !== 32'h300) begin errors++; $display("FAIL wait_return_pc: got %h expected 00000300", rpc1); end
  endtask

  task automatic test_pending_reentry();
    int nf, ra, bad;
    logic [31:0] rpc, rpc1;
    logic rv1, tm1, tm2, fl2;
    do_entry(6'b000100, 32'h480, 0, nf, ra, rpc, bad);
    step();
    set_flags(6'b010000);
    step();
    set_flags(6'b0);
    step();
    pc_in = 32'h0000_0a00;
    do_return(rv1, rpc1, tm1, tm2, fl2);
    checks++;
    if ({rv1, rpc1} !== {1'b1, 32'h480}) begin
      errors++; $display("FAIL pend_return: got %b/%h expected 1/00000480", rv1, rpc1);
    end
    checks++;
    if ({tm2, fl2} !== 2'b00) begin errors++; $display("FAIL pend_gap: got %b expected 00", {tm2, fl2}); end
    watch_entry(0, nf, ra, rpc, bad);
    checks++;
    if (ra !== 3 || nf !== 1) begin
      errors++; $display("FAIL pend_reentry_timing: got redirect %0d flush %0d expected 3 1", ra, nf);
    end
    checks++;
    if (rpc !== 32'h150) begin errors++; $display("FAIL pend_vector: got %h expected 00000150", rpc); end
    step();
    checks++;
    if ({cause, epc} !== {3'd5, 32'h0a00}) begin
      errors++; $display("FAIL pend_cause_epc: got %0d/%h expected 5/00000a00", cause, epc);
    end
    do_return(rv1, rpc1, tm1, tm2, fl2);
  endtask

  task automatic test_random();
    int nf, ra, bad, d, retrap;
    logic [5:0] f;
    logic [31:0] pc, rpc, rpc1;
    logic [2:0] ec;
    logic rv1, tm1, tm2, fl2;
    for (int it = 0; it < 8; it++) begin
      f  = 6'($urandom_range(1, 63));
      pc = $urandom & 32'hffff_fffc;
      d  = $urandom_range(0, 3);
      ec = model_cause(f);
      do_entry(f, pc, d, nf, ra, rpc, bad);
      checks++;
      if (nf !== d + 1 || ra !== d + 3 || bad !== 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got flush %0d redirect %0d bad %0d expected %0d %0d 0",
                 it, nf, ra, bad, d + 1, d + 3);
      end
      checks++;
      if (rpc !== model_vector(ec)) begin
        errors++; $display("FAIL rand_vector[%0d]: got %h expected %h", it, rpc, model_vector(ec));
      end
      step();
      checks++;
      if ({trap_mode, cause, epc} !== {1'b1, ec, pc}) begin
        errors++;
        $display("FAIL rand_handler[%0d]: got %b/%0d/%h expected 1/%0d/%h", it, trap_mode, cause, epc, ec, pc);
      end
      do_return(rv1, rpc1, tm1, tm2, fl2);
      checks++;
      if ({rv1, tm1, tm2, rpc1} !== {3'b110, pc}) begin
        errors++;
        $display("FAIL rand_return[%0d]: got %b%b%b/%h expected 110/%h", it, rv1, tm1, tm2, rpc1, pc);
      end
      retrap = 0;
      for (int i = 0; i < 3; i++) begin step(); if (flush) retrap++; end
      checks++;
      if (retrap !== 0) begin errors++; $display("FAIL rand_no_retrap[%0d]: got %0d expected 0", it, retrap); end
    end
  endtask

  task automatic test_halt();
    int nf, ra, bad, leak;
    logic [31:0] rpc;
    do_entry(6'b001000, 32'h500, 0, nf, ra, rpc, bad);
    step();
    set_flags(6'b000001);
    return_from_trap = 1'b1;
    step();
    set_flags(6'b0);
    return_from_trap = 1'b0;
    step();
    checks++;
    if ({halted, stall, trap_mode, redirect_valid} !== 4'b1110) begin
      errors++;
      $display("FAIL halt_enter: got %b expected 1110", {halted, stall, trap_mode, redirect_valid});
    end
    leak = 0;
    for (int i = 0; i < 4; i++) begin
      return_from_trap = (i == 1);
      set_flags(i == 2 ? 6'b000100 : 6'b0);
      step();
      if (!halted || redirect_valid || flush) leak++;
    end
    set_flags(6'b0);
    return_from_trap = 1'b0;
    checks++;
    if (leak !== 0) begin errors++; $display("FAIL halt_absorbing: got %0d bad cycles expected 0", leak); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b expected 0", halted); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset_in_flush();
    int nf, ra, bad;
    logic [31:0] rpc;
    set_flags(6'b001000);
    pc_in = 32'h600;
    pipeline_empty = 1'b0;
    step();
    set_flags(6'b0);
    step();
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL rstflush_pre: got %b expected 1", flush); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({stall, flush, redirect_valid, flags_clear, trap_mode, halted, cause, epc, redirect_pc} !== '0) begin
      errors++;
      $display("FAIL rstflush_async: got ctrl %b cause %0d epc %h rpc %h expected all 0",
               {stall, flush, redirect_valid, flags_clear, trap_mode, halted}, cause, epc, redirect_pc);
    end
    reset = 1'b0;
    pipeline_empty = 1'b1;
    step(); step();
    checks++;
    if ({flush, stall} !== 2'b00) begin errors++; $display("FAIL rstflush_idle: got %b expected 00", {flush, stall}); end
    do_entry(6'b000100, 32'h700, 0, nf, ra, rpc, bad);
    step();
    checks++;
    if ({ra, rpc, cause, epc} !== {32'd3, 32'h130, 3'd3, 32'h700}) begin
      errors++;
      $display("FAIL rstflush_fresh: got %0d/%h/%0d/%h expected 3/00000130/3/00000700", ra, rpc, cause, epc);
    end
  endtask

  initial begin
    test_reset();
    test_return_ignored();
    test_basic();
    test_priority();
    test_flush_wait();
    test_pending_reentry();
    test_random();
    test_halt();
    test_reset_in_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
